// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences a WIDTH-bit up/down count from a programmed load value to a
// terminal value. It supports one-shot, auto-reload and ping-pong modes, pause and abort.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-low reset
//   start     request a new sequence (accepted only in IDLE)
//   stop      abort the running or paused sequence
//   pause     level; holds the count while high
//   tick      count-enable strobe, one step per cycle
//   dir       initial direction, 1 = up (sampled at start)
//   mode      00 one-shot, 01 auto-reload, 10 ping-pong, 11 one-shot (sampled at start)
//   load_val  start value (sampled at start)
//   term_val  terminal value (sampled at start)
//   count     current count
//   dir_o     current direction
//   busy      high in RUN or PAUSED
//   done      one-cycle pulse when a one-shot sequence completes
//   wrap      one-cycle pulse on each reload or turnaround
module counter_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             tick,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             dir_o,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StDone
    } state_e;

    localparam logic [1:0] ModeReload   = 2'b01;
    localparam logic [1:0] ModePingPong = 2'b10;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    logic             at_target;
    logic [WIDTH-1:0] count_up;
    logic [WIDTH-1:0] count_dn;

    assign at_target = (count_q == target_q);
    // Natural modulo-2^WIDTH roll-over is the intended behaviour in both directions.
    assign count_up  = count_q + WIDTH'(1);
    assign count_dn  = count_q - WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        load_d   = load_q;
        term_d   = term_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load_d   = load_val;
                    term_d   = term_val;
                    mode_d   = mode;
                    dir_d    = dir;
                    count_d  = load_val;
                    target_d = term_val;
                    state_d  = StRun;
                end
            end

            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (pause) begin
                    state_d = StPaused;
                end else if (tick) begin
                    if (!at_target) begin
                        count_d = dir_q ? count_up : count_dn;
                    end else begin
                        // Terminal check precedes stepping, so load == term ends on the
                        // first tick.
                        case (mode_q)
                            ModeReload: begin
                                count_d = load_q;
                                wrap_d  = 1'b1;
                            end
                            ModePingPong: begin
                                wrap_d = 1'b1;
                                if (load_q == term_q) begin
                                    // Degenerate bounce: behaves like a reload.
                                    count_d = load_q;
                                end else begin
                                    dir_d    = ~dir_q;
                                    target_d = (target_q == term_q) ? load_q : term_q;
                                    // Step one in the new direction.
                                    count_d  = dir_q ? count_dn : count_up;
                                end
                            end
                            default: begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end

            StPaused: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            target_q <= '0;
            load_q   <= '0;
            term_q   <= '0;
            mode_q   <= '0;
            dir_q    <= 1'b1;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            load_q   <= load_d;
            term_q   <= term_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign count = count_q;
    assign dir_o = dir_q;
    assign busy  = (state_q == StRun) || (state_q == StPaused);
    assign done  = done_q;
    assign wrap  = wrap_q;

endmodule
